// File: rtl/openhw_ram2p1r1wbe_pipe.sv
// openhw_ram2p1r1wbe_pipe: 1-read / 1-write byte-enabled RAM for cache arrays.
// Adds a 1- or 2-cycle read pipeline with valid tracking, same-cycle
// write-to-read bypass, and a post-reset init sweep that fills every word
// with INITVAL before either port is honoured.
// Optional feature: define OPENHW_RAM2P_PARITY_EN to store one even-parity
// bit per byte lane, adding the perr output and errinj2 input.
module openhw_ram2p1r1wbe_pipe #(
  parameter int unsigned     DEPTH   = 1024,
  parameter int unsigned     WIDTH   = 68,
  parameter int unsigned     RDLAT   = 1,
  parameter int unsigned     BYPASS  = 1,
  parameter logic [WIDTH-1:0] INITVAL = '0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       ce1,
  input  logic [$clog2(DEPTH)-1:0]   ra1,
  output logic [WIDTH-1:0]           rd1,
  output logic                       rvalid1,
  input  logic                       ce2,
  input  logic                       we2,
  input  logic [$clog2(DEPTH)-1:0]   wa2,
  input  logic [WIDTH-1:0]           wd2,
  input  logic [(WIDTH-1)/8:0]       bwe2,
`ifdef OPENHW_RAM2P_PARITY_EN
  output logic                       perr,
  input  logic                       errinj2,
`endif
  output logic                       initbusy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned NB = (WIDTH - 1) / 8 + 1;

  if (RDLAT != 1 && RDLAT != 2) begin : g_bad_rdlat
    $error("openhw_ram2p1r1wbe_pipe: RDLAT must be 1 or 2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("openhw_ram2p1r1wbe_pipe: DEPTH must be a power of two >= 2");
  end

  typedef enum logic {ST_INIT, ST_READY} state_e;

  // Expand per-lane byte enables to a per-bit mask; the last lane may be short.
  function automatic logic [WIDTH-1:0] lane_mask(input logic [NB-1:0] be);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int b = 0; b < int'(WIDTH); b++) m[b] = be[b/8];
    return m;
  endfunction

  // Even parity per byte lane: each bit is the XOR of its lane's data bits.
  function automatic logic [NB-1:0] lane_par(input logic [WIDTH-1:0] d);
    logic [NB-1:0] p;
    p = '0;
    for (int b = 0; b < int'(WIDTH); b++) p[b/8] = p[b/8] ^ d[b];
    return p;
  endfunction

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              ready;
  logic              wen;
  logic [AW-1:0]     waddr;
  logic [WIDTH-1:0]  wdata;
  logic [WIDTH-1:0]  wmask;
  logic              rd_en;
  logic              collide;
  logic [WIDTH-1:0]  rword;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic              s1_valid_q;
  logic [WIDTH-1:0]  s1_data_q;

  // State register and sweep counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: sweep one word per cycle, leave INIT after writing DEPTH-1.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == AW'(DEPTH - 1)) state_d = ST_READY;
    end
  end

  // Outputs of the FSM: select sweep or user write, gate the read port.
  always_comb begin
    ready    = (state_q == ST_READY);
    initbusy = !ready;
    wen      = 1'b1;
    waddr    = cnt_q;
    wdata    = INITVAL;
    wmask    = '1;
    rd_en    = 1'b0;
    if (ready) begin
      wen   = ce2 & we2;
      waddr = wa2;
      wdata = wd2;
      wmask = lane_mask(bwe2);
      rd_en = ce1;
    end
  end

  // Read-side data select: old contents, or merged new lanes on a collision.
  always_comb begin
    collide = ready & ce2 & we2 & (ra1 == wa2);
    rword   = mem_q[ra1];
    if (BYPASS != 0 && collide) rword = (mem_q[ra1] & ~wmask) | (wd2 & wmask);
  end

  // Storage array: masked read-modify-write of the addressed word.
  // NOTE: the array is not reset; the init sweep gives it defined contents.
  always_ff @(posedge clk) begin
    if (wen) mem_q[waddr] <= (mem_q[waddr] & ~wmask) | (wdata & wmask);
  end

  // First read stage: valid every cycle, data only on an accepted read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= rd_en;
      if (rd_en) s1_data_q <= rword;
    end
  end

`ifdef OPENHW_RAM2P_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];
  logic [NB-1:0] wpar;
  logic [NB-1:0] wpar_en;
  logic [NB-1:0] rpar;
  logic [NB-1:0] s1_par_q;
  logic [NB-1:0] out_par;

  // Parity write/read select; injection flips written lanes, bypass stays clean.
  always_comb begin
    wpar    = lane_par(wdata);
    wpar_en = '1;
    if (ready) begin
      wpar    = lane_par(wd2) ^ ({NB{errinj2}} & bwe2);
      wpar_en = bwe2;
    end
    rpar = par_q[ra1];
    if (BYPASS != 0 && collide) rpar = (par_q[ra1] & ~bwe2) | (lane_par(wd2) & bwe2);
  end

  // Parity array, written alongside the data lanes.
  always_ff @(posedge clk) begin
    if (wen) par_q[waddr] <= (par_q[waddr] & ~wpar_en) | (wpar & wpar_en);
  end

  // First-stage parity register, tracking s1_data_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) s1_par_q <= '0;
    else if (rd_en) s1_par_q <= rpar;
  end
`endif

  if (RDLAT == 2) begin : g_lat2
    logic             s2_valid_q;
    logic [WIDTH-1:0] s2_data_q;

    // Second read stage: one more register, holding data between reads.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) s2_data_q <= s1_data_q;
      end
    end
    assign rd1     = s2_data_q;
    assign rvalid1 = s2_valid_q;
`ifdef OPENHW_RAM2P_PARITY_EN
    logic [NB-1:0] s2_par_q;

    // Second-stage parity register, tracking s2_data_q.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) s2_par_q <= '0;
      else if (s1_valid_q) s2_par_q <= s1_par_q;
    end
    assign out_par = s2_par_q;
`endif
  end else begin : g_lat1
    assign rd1     = s1_data_q;
    assign rvalid1 = s1_valid_q;
`ifdef OPENHW_RAM2P_PARITY_EN
    assign out_par = s1_par_q;
`endif
  end

`ifdef OPENHW_RAM2P_PARITY_EN
  assign perr = rvalid1 && (lane_par(rd1) != out_par);
`endif

endmodule

// File: tb/tb_openhw_ram2p1r1wbe_pipe.sv
// Directed bench for openhw_ram2p1r1wbe_pipe. Two instances share stimulus:
// u_a (RDLAT=1, BYPASS=1) and u_b (RDLAT=2, BYPASS=0), DEPTH=16, WIDTH=68,
// INITVAL=0xA5. Parity checks run when OPENHW_RAM2P_PARITY_EN is defined.
module tb_openhw_ram2p1r1wbe_pipe;

  logic        clk;
  logic        reset_n;
  logic        ce1;
  logic [3:0]  ra1;
  logic        ce2;
  logic        we2;
  logic [3:0]  wa2;
  logic [67:0] wd2;
  logic [8:0]  bwe2;
  logic [67:0] a_rd1, b_rd1;
  logic        a_rvalid1, b_rvalid1;
  logic        a_initbusy, b_initbusy;
`ifdef OPENHW_RAM2P_PARITY_EN
  logic        errinj2;
  logic        a_perr, b_perr;
`endif

  int n_cmp = 0;
  int n_err = 0;

  openhw_ram2p1r1wbe_pipe #(
    .DEPTH(16), .WIDTH(68), .RDLAT(1), .BYPASS(1), .INITVAL(68'hA5)
  ) u_a (
    .clk(clk), .reset_n(reset_n), .ce1(ce1), .ra1(ra1), .rd1(a_rd1),
    .rvalid1(a_rvalid1), .ce2(ce2), .we2(we2), .wa2(wa2), .wd2(wd2),
    .bwe2(bwe2),
`ifdef OPENHW_RAM2P_PARITY_EN
    .perr(a_perr), .errinj2(errinj2),
`endif
    .initbusy(a_initbusy)
  );

  openhw_ram2p1r1wbe_pipe #(
    .DEPTH(16), .WIDTH(68), .RDLAT(2), .BYPASS(0), .INITVAL(68'hA5)
  ) u_b (
    .clk(clk), .reset_n(reset_n), .ce1(ce1), .ra1(ra1), .rd1(b_rd1),
    .rvalid1(b_rvalid1), .ce2(ce2), .we2(we2), .wa2(wa2), .wd2(wd2),
    .bwe2(bwe2),
`ifdef OPENHW_RAM2P_PARITY_EN
    .perr(b_perr), .errinj2(errinj2),
`endif
    .initbusy(b_initbusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs and samples sit 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [67:0] data,
                    input logic [8:0] be, input logic inj);
    ce2 = 1'b1; we2 = 1'b1; wa2 = addr; wd2 = data; bwe2 = be;
`ifdef OPENHW_RAM2P_PARITY_EN
    errinj2 = inj;
`else
    if (inj) $display("note: error injection requested without parity build");
`endif
    tick();
    ce2 = 1'b0; we2 = 1'b0;
`ifdef OPENHW_RAM2P_PARITY_EN
    errinj2 = 1'b0;
`endif
  endtask

  // Single read, checking u_a one cycle later and u_b two cycles later.
  task automatic rd_check(input string tag, input logic [3:0] addr,
                          input logic [67:0] exp_a, input logic [67:0] exp_b);
    ce1 = 1'b1; ra1 = addr;
    tick();
    ce1 = 1'b0;
    check({tag, "_a_v"}, 68'(a_rvalid1), 68'd1);
    check({tag, "_a_d"}, a_rd1, exp_a);
    check({tag, "_b_v_early"}, 68'(b_rvalid1), 68'd0);
    tick();
    check({tag, "_b_v"}, 68'(b_rvalid1), 68'd1);
    check({tag, "_b_d"}, b_rd1, exp_b);
    check({tag, "_a_v_drop"}, 68'(a_rvalid1), 68'd0);
    check({tag, "_a_hold"}, a_rd1, exp_a);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    logic rv_seen;
    reset_n = 1'b1; ce1 = 1'b0; ra1 = '0; ce2 = 1'b0; we2 = 1'b0;
    wa2 = '0; wd2 = '0; bwe2 = '0;
`ifdef OPENHW_RAM2P_PARITY_EN
    errinj2 = 1'b0;
`endif
    #1 reset_n = 1'b0;
    #2;
    check("rst_a_busy", 68'(a_initbusy), 68'd1);
    check("rst_a_rv", 68'(a_rvalid1), 68'd0);
    check("rst_a_rd", a_rd1, 68'd0);
    check("rst_b_rv", 68'(b_rvalid1), 68'd0);
    check("rst_b_rd", b_rd1, 68'd0);
`ifdef OPENHW_RAM2P_PARITY_EN
    check("rst_a_perr", 68'(a_perr), 68'd0);
`endif
    tick(); tick();

    // First sweep, interrupted at cycle 7 with a read requested throughout.
    reset_n = 1'b1;
    ce1 = 1'b1; ra1 = 4'd2;
    repeat (7) tick();
    check("sweep7_a_busy", 68'(a_initbusy), 68'd1);
    check("sweep7_a_rv", 68'(a_rvalid1), 68'd0);
    check("sweep7_b_rv", 68'(b_rvalid1), 68'd0);
    reset_n = 1'b0;
    ce1 = 1'b0;
    #2;
    check("pulse_a_busy", 68'(a_initbusy), 68'd1);
    tick();
    reset_n = 1'b1;

    // Full sweep; reads and a write to addr 4 must be ignored meanwhile.
    ce1 = 1'b1; ra1 = 4'd4;
    ce2 = 1'b1; we2 = 1'b1; wa2 = 4'd4; wd2 = 68'd0; bwe2 = 9'h1FF;
    n = 0; rv_seen = 1'b0;
    while (a_initbusy && n < 40) begin
      n++;
      if (a_rvalid1 || b_rvalid1) rv_seen = 1'b1;
      tick();
    end
    ce1 = 1'b0; ce2 = 1'b0; we2 = 1'b0;
    check("init_cycles", 68'(n), 68'd16);
    check("init_b_busy", 68'(b_initbusy), 68'd0);
    check("init_no_rvalid", 68'(rv_seen), 68'd0);

    // Read every address back to back.
    for (int i = 0; i < 18; i++) begin
      ce1 = (i < 16); ra1 = 4'(i);
      tick();
      check($sformatf("sw_a_v%0d", i), 68'(a_rvalid1), 68'(i < 16));
      if (i < 16) check($sformatf("sw_a_d%0d", i), a_rd1, 68'hA5);
      check($sformatf("sw_b_v%0d", i), 68'(b_rvalid1), 68'(i >= 1 && i <= 16));
      if (i >= 1 && i <= 16) check($sformatf("sw_b_d%0d", i), b_rd1, 68'hA5);
    end
    ce1 = 1'b0;

    // Byte-enabled partial write, read in the cycle right after the write.
    wr(4'd3, 68'h0_FFFF_FFFF_FFFF_FFFF, 9'h1FF, 1'b0);
    wr(4'd3, 68'h5_1234_5678_9ABC_DEF0, 9'b1_0000_0011, 1'b0);
    rd_check("bwe", 4'd3, 68'h5_FFFF_FFFF_FFFF_DEF0, 68'h5_FFFF_FFFF_FFFF_DEF0);

    // Same-cycle collision at addr 5 with only lane 0 enabled.
    wr(4'd5, 68'd0, 9'h1FF, 1'b0);
    ce1 = 1'b1; ra1 = 4'd5;
    ce2 = 1'b1; we2 = 1'b1; wa2 = 4'd5; wd2 = 68'hF_FFFF_FFFF_FFFF_FFFF; bwe2 = 9'h001;
    tick();
    ce1 = 1'b0; ce2 = 1'b0; we2 = 1'b0;
    check("col_a_v", 68'(a_rvalid1), 68'd1);
    check("col_a_bypass", a_rd1, 68'hFF);
    tick();
    check("col_b_v", 68'(b_rvalid1), 68'd1);
    check("col_b_old", b_rd1, 68'd0);
    rd_check("col_after", 4'd5, 68'hFF, 68'hFF);

    // Independent read and write at different addresses.
    ce1 = 1'b1; ra1 = 4'd3;
    ce2 = 1'b1; we2 = 1'b1; wa2 = 4'd6; wd2 = 68'h9_0000_0000_0000_0077; bwe2 = 9'h1FF;
    tick();
    ce1 = 1'b0; ce2 = 1'b0; we2 = 1'b0;
    check("ind_a_d", a_rd1, 68'h5_FFFF_FFFF_FFFF_DEF0);
    tick();
    check("ind_b_d", b_rd1, 68'h5_FFFF_FFFF_FFFF_DEF0);
    rd_check("ind_wr", 4'd6, 68'h9_0000_0000_0000_0077, 68'h9_0000_0000_0000_0077);

    // Pipelined reads of addrs 0,1,2 and data hold afterwards.
    wr(4'd0, 68'h11, 9'h1FF, 1'b0);
    wr(4'd1, 68'h22, 9'h1FF, 1'b0);
    wr(4'd2, 68'h33, 9'h1FF, 1'b0);
    ce1 = 1'b1; ra1 = 4'd0;
    tick();
    check("pl1_a", a_rd1, 68'h11);
    check("pl1_b_v", 68'(b_rvalid1), 68'd0);
    ra1 = 4'd1;
    tick();
    check("pl2_a", a_rd1, 68'h22);
    check("pl2_b_v", 68'(b_rvalid1), 68'd1);
    check("pl2_b", b_rd1, 68'h11);
    ra1 = 4'd2;
    tick();
    ce1 = 1'b0;
    check("pl3_a", a_rd1, 68'h33);
    check("pl3_b_v", 68'(b_rvalid1), 68'd1);
    check("pl3_b", b_rd1, 68'h22);
    tick();
    check("pl4_a_v", 68'(a_rvalid1), 68'd0);
    check("pl4_a_hold", a_rd1, 68'h33);
    check("pl4_b_v", 68'(b_rvalid1), 68'd1);
    check("pl4_b", b_rd1, 68'h33);
    tick();
    check("pl5_b_v", 68'(b_rvalid1), 68'd0);
    check("pl5_b_hold", b_rd1, 68'h33);
    tick();
    check("pl6_b_hold", b_rd1, 68'h33);

`ifdef OPENHW_RAM2P_PARITY_EN
    // Injected parity error on addr 9, then a clean rewrite.
    wr(4'd9, 68'h3C, 9'h1FF, 1'b1);
    ce1 = 1'b1; ra1 = 4'd9;
    tick();
    ce1 = 1'b0;
    check("par_a_v", 68'(a_rvalid1), 68'd1);
    check("par_a_perr", 68'(a_perr), 68'd1);
    tick();
    check("par_b_perr", 68'(b_perr), 68'd1);
    check("par_a_perr_drop", 68'(a_perr), 68'd0);
    wr(4'd9, 68'h3C, 9'h1FF, 1'b0);
    ce1 = 1'b1; ra1 = 4'd9;
    tick();
    ce1 = 1'b0;
    check("par_clean_a_v", 68'(a_rvalid1), 68'd1);
    check("par_clean_a", 68'(a_perr), 68'd0);
    tick();
    check("par_clean_b_v", 68'(b_rvalid1), 68'd1);
    check("par_clean_b", 68'(b_perr), 68'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/openhw_ram2p1r1wbe_pipe.md
Name: openhw_ram2p1r1wbe_pipe

Overview:
Parametrised 1-read/1-write byte-enabled RAM for cache data, tag, and replacement arrays. It adds the following to the basic 1R1W array:
- selectable read latency of 1 or 2 cycles;
- read-valid tracking;
- same-cycle write-to-read bypass;
- hardware init sweep after reset, clearing the array before the cache uses it.
It sits between the cache controller and the storage array. Ports mirror the basic array, so a cache can swap it in directly.

Parameters:
DEPTH, 1024, number of words; power of two, >= 2
WIDTH, 68, bits per word; any value >= 1
RDLAT, 1, read latency in cycles; legal values 1 or 2, anything else is an elaboration error
BYPASS, 1, 1 = same-cycle write/read collision returns merged new data; 0 = returns old data (read-first)
INITVAL, 0, WIDTH-bit value written to every word during the init sweep

Ports:
clk  in  1  single clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
ce1  in  1  read port enable
ra1  in  $clog2(DEPTH)  read address
rd1  out  WIDTH  read data
rvalid1  out  1  rd1 carries data for a read accepted RDLAT cycles earlier
ce2  in  1  write port enable
we2  in  1  write enable
wa2  in  $clog2(DEPTH)  write address
wd2  in  WIDTH  write data
bwe2  in  (WIDTH-1)/8+1  byte write enables; the top bit covers the WIDTH%8 MSBs when WIDTH is not a multiple of 8
initbusy  out  1  init sweep in progress; both ports are ignored while this is high

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=INIT, sweep counter=0.
  - rd1=0, rvalid1=0, all pipeline registers=0, initbusy=1.
  - Array contents are unspecified until the sweep completes.
- States are INIT and READY.
- INIT:
  - Each cycle writes INITVAL to word[counter], all lanes, then counter increments.
  - On the cycle that writes DEPTH-1, the next state is READY. The sweep therefore takes exactly DEPTH cycles after reset_n rises.
  - initbusy drops on the first READY cycle.
  - ce1/ce2 are ignored; rvalid1 stays 0.
  - Reset mid-sweep restarts the sweep from counter 0.
- READY read:
  - ce1=1 in cycle N samples ra1.
  - RDLAT=1: rd1 = word at edge N+1; rvalid1=1 during cycle N+1.
  - RDLAT=2: a second register stage is added; data appears in cycle N+2; rvalid1=1 during cycle N+2.
  - Back-to-back reads are fully pipelined, one per cycle.
  - rd1 holds its last value when no new read is completing.
  - rvalid1 is 0 in any cycle without a completing read.
- READY write:
  - ce2&we2 in cycle N writes lanes with bwe2[i]=1 at edge N+1.
  - Lanes with bwe2[i]=0 keep their old contents.
  - A read of the same address in N+1 returns the new data.
- Collision (ce1 & ce2 & we2, ra1==wa2, same cycle):
  - BYPASS=1: the returned word = wd2 lanes where bwe2=1, old lanes elsewhere.
  - BYPASS=0: the returned word = old contents.
  - The write always completes.
- Different-address simultaneous read and write are independent.
- Address wrap does not occur: addresses are exactly $clog2(DEPTH) bits wide.

Optional Feature:
Macro: OPENHW_RAM2P_PARITY_EN

Defined:
- The array stores one even-parity bit per byte lane (WIDTH%8 lane included), computed from wd2 on write. INIT writes parity of INITVAL.
- Added ports:
  - perr (out, 1): asserted with rvalid1 when any lane's recomputed parity mismatches; 0 otherwise; reset 0.
  - errinj2 (in, 1): when high on a write, stored parity of every written lane is inverted.
- Bypassed collision data always carries correct parity, ignoring errinj2.

Undefined:
- No parity storage, and no perr or errinj2 ports.

Test Plan:
- DEPTH=16, INITVAL=0xA5: release reset -> initbusy=1 for exactly 16 cycles; a read of every address -> 0xA5 with rvalid1 RDLAT cycles after ce1.
- Reset pulsed at sweep cycle 7 -> counter restarts; initbusy lasts 16 cycles from the new reset_n release.
- WIDTH=68, write 0x0_FFFF_FFFF_FFFF_FFFF to addr 3, then write 0x5_1234_5678_9ABC_DEF0 with bwe2=9'b1_0000_0011 -> read addr 3 = 0x5_FFFF_FFFF_FFFF_DEF0.
- Collision at addr 5, old=0, wd2=0xFF..FF, bwe2 lane0 only -> BYPASS=1 returns 0x00..FF; BYPASS=0 returns 0; a subsequent read returns 0x00..FF in both cases.
- RDLAT=2, reads of addrs 0,1,2 in consecutive cycles -> data in cycles +2,+3,+4 with rvalid1 high for 3 cycles; rd1 holds the addr-2 data afterwards with rvalid1=0.
- With OPENHW_RAM2P_PARITY_EN defined: write addr 9 with errinj2=1 -> read addr 9 gives perr=1 with rvalid1; rewrite with errinj2=0 -> perr=0.
